// File: rtl/sync_fifo_gen2_if.sv
// ----------------------------------------------------------------------------
// sync_fifo_gen2_if
// Bundles the write/read handshake, data and status signals of sync_fifo_gen2.
//   master : the user side. Drives din, wr_en, rd_en and flag_clr. Observes
//            dout, the level flags, the sticky error flags and usedw.
//   slave  : the FIFO side. It has the opposite directions.
// Clock and reset are not part of the bundle. They are plain module ports.
// ----------------------------------------------------------------------------
interface sync_fifo_gen2_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    logic [DATA_WIDTH-1:0]        din;
    logic                         wr_en;
    logic                         rd_en;
    logic                         flag_clr;
    logic [DATA_WIDTH-1:0]        dout;
    logic                         full;
    logic                         almost_full;
    logic                         empty;
    logic                         almost_empty;
    logic                         overflow;
    logic                         underflow;
    logic [$clog2(DEPTH+1)-1:0]   usedw;

    modport master (
        output din, wr_en, rd_en, flag_clr,
        input  dout, full, almost_full, empty, almost_empty,
               overflow, underflow, usedw
    );

    modport slave (
        input  din, wr_en, rd_en, flag_clr,
        output dout, full, almost_full, empty, almost_empty,
               overflow, underflow, usedw
    );
endinterface

// File: rtl/sync_fifo_gen2.sv
// ----------------------------------------------------------------------------
// sync_fifo_gen2
// Single-clock FIFO. DEPTH can be any value of 2 or more, including values that
// are not a power of two. The status flags are registered, and the overflow and
// underflow error flags are sticky.
//   clk   : rising-edge clock
//   sclr  : synchronous active-high clear. It discards all stored words.
//   bus   : sync_fifo_gen2_if.slave, with these signals:
//           din/wr_en         write data and write request
//           rd_en             read request. In show-ahead mode it acknowledges
//                             the pop of the word on dout.
//           flag_clr          clears overflow and underflow
//           dout              read data
//           full/almost_full/empty/almost_empty, usedw   level status
//           overflow/underflow                           sticky error flags
// SHOW_AHEAD=0 : a read loads dout one cycle after rd_en.
// SHOW_AHEAD=1 : dout shows the head word while the FIFO is not empty, and 0
//                when it is empty.
// ----------------------------------------------------------------------------
module sync_fifo_gen2 #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int SHOW_AHEAD = 0,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic             clk,
    input  logic             sclr,
    sync_fifo_gen2_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      usedw_q;
    logic [CNT_W-1:0]      usedw_nxt;
    logic                  full_q;
    logic                  empty_q;
    logic                  afull_q;
    logic                  aempty_q;
    logic                  ovf_q;
    logic                  udf_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ovf_set;
    logic                  udf_set;

    // The FIFO accepts a write while full only when a read frees a slot in
    // the same cycle. A write into an empty FIFO cannot be read in that cycle.
    assign rd_acc  = bus.rd_en && !empty_q;
    assign wr_acc  = bus.wr_en && (!full_q || rd_acc);
    assign ovf_set = bus.wr_en && full_q && !rd_acc;
    assign udf_set = bus.rd_en && empty_q;

    // The pointers wrap explicitly, so DEPTH does not have to be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // The next occupancy already includes the clear. Because of this, the
    // registered flags below are always computed from the same value as usedw.
    // NOTE: a combinational block assigns every output a default first.
    // Without the default, a path that skips the assignment infers a latch.
    always_comb begin
        usedw_nxt = usedw_q;
        if (sclr) begin
            usedw_nxt = '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   usedw_nxt = usedw_q + CNT_W'(1);
                2'b01:   usedw_nxt = usedw_q - CNT_W'(1);
                default: usedw_nxt = usedw_q;
            endcase
        end
    end

    // NOTE: clocked state uses non-blocking assignments. Every register then
    // samples values from before the edge, so there are no ordering races
    // between blocks.
    always_ff @(posedge clk) begin
        usedw_q  <= usedw_nxt;
        full_q   <= (usedw_nxt == CNT_FULL);
        empty_q  <= (usedw_nxt == '0);
        afull_q  <= (int'(usedw_nxt) >= AF_LEVEL);
        aempty_q <= (int'(usedw_nxt) <= AE_LEVEL);
        if (sclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
            // A new error in the same cycle as flag_clr leaves the flag set.
            ovf_q <= ovf_set || (ovf_q && !bus.flag_clr);
            udf_q <= udf_set || (udf_q && !bus.flag_clr);
        end
    end

    // NOTE: the storage array has no reset. dout is gated by empty or by
    // rd_acc, so stale entries never reach the output, and leaving the array
    // unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_acc && !sclr) mem[wr_ptr] <= bus.din;
    end

    generate
        if (SHOW_AHEAD != 0) begin : g_show_ahead
            assign bus.dout = empty_q ? '0 : mem[rd_ptr];
        end else begin : g_normal
            logic [DATA_WIDTH-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (sclr)        dout_q <= '0;
                else if (rd_acc) dout_q <= mem[rd_ptr];
            end
            assign bus.dout = dout_q;
        end
    endgenerate

    assign bus.usedw        = usedw_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_gen2.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo_gen2
// Two instances share one stimulus: a normal-mode FIFO (u_dut0) and a
// show-ahead FIFO (u_dut1), both with DEPTH=5 and 8-bit data. A queue-based
// model predicts every output, and the outputs are compared on each falling
// edge. Hand-computed literals pin the directed scenarios.
// ----------------------------------------------------------------------------
module tb_sync_fifo_gen2;
    localparam int DW    = 8;
    localparam int DEPTH = 5;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          sclr;
    logic          wr_en;
    logic          rd_en;
    logic          flag_clr;
    logic [DW-1:0] din;

    always #5 clk = ~clk;

    sync_fifo_gen2_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus0 ();
    sync_fifo_gen2_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus1 ();

    assign bus0.din = din;  assign bus0.wr_en = wr_en;
    assign bus0.rd_en = rd_en;  assign bus0.flag_clr = flag_clr;
    assign bus1.din = din;  assign bus1.wr_en = wr_en;
    assign bus1.rd_en = rd_en;  assign bus1.flag_clr = flag_clr;

    sync_fifo_gen2 #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SHOW_AHEAD(0),
                     .AF_LEVEL(AF), .AE_LEVEL(AE))
        u_dut0 (.clk(clk), .sclr(sclr), .bus(bus0));

    sync_fifo_gen2 #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SHOW_AHEAD(1),
                     .AF_LEVEL(AF), .AE_LEVEL(AE))
        u_dut1 (.clk(clk), .sclr(sclr), .bus(bus1));

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: the contents as a queue, plus the sticky flags and the
    // normal-mode output register.
    int            q[$];
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;
    logic [DW-1:0] m_dout0 = '0;
    bit            chk_en = 1'b0;
    int            m_n;
    logic [DW-1:0] m_dout1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_update(input bit w, input bit r, input logic [DW-1:0] d,
                                input bit fc, input bit clr);
        bit ra, wa, os, us;
        if (clr) begin
            q.delete();
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_dout0 = '0;
        end else begin
            ra = r && (q.size() > 0);
            wa = w && ((q.size() < DEPTH) || ra);
            os = w && (q.size() == DEPTH) && !ra;
            us = r && (q.size() == 0);
            if (ra) m_dout0 = DW'(q.pop_front());
            if (wa) q.push_back(int'(d));
            m_ovf = os || (m_ovf && !fc);
            m_udf = us || (m_udf && !fc);
        end
    endtask

    // One clock cycle. Inputs are held across the rising edge. The model then
    // advances with the same inputs, and the caller continues 1 time unit
    // after the edge.
    task automatic step(input bit w, input bit r, input logic [DW-1:0] d,
                        input bit fc, input bit clr);
        wr_en = w;  rd_en = r;  din = d;  flag_clr = fc;  sclr = clr;
        @(posedge clk);
        model_update(w, r, d, fc, clr);
        #1;
    endtask

    // The compare process checks every output of both instances on each
    // falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            m_n     = q.size();
            m_dout1 = (m_n == 0) ? '0 : DW'(q[0]);
            check("usedw0",  32'(bus0.usedw),  m_n);
            check("usedw1",  32'(bus1.usedw),  m_n);
            check("full0",   bus0.full,        32'(m_n == DEPTH));
            check("full1",   bus1.full,        32'(m_n == DEPTH));
            check("empty0",  bus0.empty,       32'(m_n == 0));
            check("empty1",  bus1.empty,       32'(m_n == 0));
            check("afull0",  bus0.almost_full, 32'(m_n >= AF));
            check("afull1",  bus1.almost_full, 32'(m_n >= AF));
            check("aempty0", bus0.almost_empty, 32'(m_n <= AE));
            check("aempty1", bus1.almost_empty, 32'(m_n <= AE));
            check("ovf0",    bus0.overflow,    32'(m_ovf));
            check("ovf1",    bus1.overflow,    32'(m_ovf));
            check("udf0",    bus0.underflow,   32'(m_udf));
            check("udf1",    bus1.underflow,   32'(m_udf));
            check("dout0",   bus0.dout,        m_dout0);
            check("dout1",   bus1.dout,        m_dout1);
        end
    end

    task automatic fill_11_55();
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, DW'(i * 8'h11), 1'b0, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] exp_seq [5];
        int            pw;
        int            pr;

        wr_en = 1'b0;  rd_en = 1'b0;  din = '0;  flag_clr = 1'b0;  sclr = 1'b1;

        // Reset state.
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk_en = 1'b1;
        check("rst_usedw",  32'(bus0.usedw), 0);
        check("rst_empty",  bus0.empty, 1);
        check("rst_full",   bus0.full, 0);
        check("rst_aempty", bus0.almost_empty, 1);
        check("rst_afull",  bus0.almost_full, 0);
        check("rst_flags",  {bus0.overflow, bus0.underflow}, 0);
        check("rst_dout0",  bus0.dout, 0);
        check("rst_dout1",  bus1.dout, 0);

        // Fill and drain.
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, DW'(i * 8'h11), 1'b0, 1'b0);
            if (i == 2) check("fill_af_at2", bus0.almost_full, 0);
            if (i == 3) check("fill_af_at3", bus0.almost_full, 1);
        end
        check("fill_full",  bus0.full, 1);
        check("fill_usedw", 32'(bus0.usedw), 5);
        check("fill_head1", bus1.dout, 8'h11);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b1, '0, 1'b0, 1'b0);
            check("drain_dout", bus0.dout, i * 8'h11);
        end
        check("drain_empty", bus0.empty, 1);

        // Wrap-around: the write pointer wraps at index 4 during the 5 writes.
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, DW'(8'h30 + i), 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b1, '0, 1'b0, 1'b0);
            check("wrap_a_dout", bus0.dout, 8'h30 + i);
        end
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, DW'(8'h60 + i), 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b1, '0, 1'b0, 1'b0);
            check("wrap_b_dout", bus0.dout, 8'h60 + i);
        end

        // Full with a simultaneous read and write.
        fill_11_55();
        step(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
        check("rw_full_usedw", 32'(bus0.usedw), 5);
        check("rw_full_full",  bus0.full, 1);
        check("rw_full_ovf",   bus0.overflow, 0);
        check("rw_full_dout",  bus0.dout, 8'h11);
        exp_seq[0] = 8'h22;  exp_seq[1] = 8'h33;  exp_seq[2] = 8'h44;
        exp_seq[3] = 8'h55;  exp_seq[4] = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, '0, 1'b0, 1'b0);
            check("rw_full_order", bus0.dout, exp_seq[i]);
        end

        // Overflow, underflow, flag_clr, and set winning over clear.
        fill_11_55();
        step(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
        check("ovf_set",   bus0.overflow, 1);
        check("ovf_usedw", 32'(bus0.usedw), 5);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b1, '0, 1'b0, 1'b0);
            check("ovf_contents", bus0.dout, i * 8'h11);
        end
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        check("udf_set",  bus0.underflow, 1);
        check("udf_dout", bus0.dout, 8'h55);
        step(1'b0, 1'b1, '0, 1'b1, 1'b0);
        check("udf_set_wins", bus0.underflow, 1);
        check("ovf_cleared",  bus0.overflow, 0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("flags_cleared", {bus0.overflow, bus0.underflow}, 0);

        // Show-ahead: the first word falls through with no rd_en.
        step(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        check("sa_empty",    bus1.empty, 0);
        check("sa_dout",     bus1.dout, 8'h5A);
        check("sa_n_hold",   bus0.dout, 8'h55);
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        check("sa_pop_empty", bus1.empty, 1);
        check("sa_pop_dout",  bus1.dout, 0);
        check("sa_n_read",    bus0.dout, 8'h5A);

        // Reset mid-operation while a write is requested.
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, DW'(8'h70 + i), 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h99, 1'b0, 1'b1);
        check("mid_rst_usedw", 32'(bus0.usedw), 0);
        check("mid_rst_empty", bus0.empty, 1);
        check("mid_rst_dout0", bus0.dout, 0);
        check("mid_rst_dout1", bus1.dout, 0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("mid_rst_nowr", 32'(bus0.usedw), 0);
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        check("mid_rst_udf", bus0.underflow, 1);

        // Randomised traffic. The write and read biases change per phase so
        // the FIFO spends time near both full and empty.
        for (int ph = 0; ph < 4; ph++) begin
            pw = (ph % 2 == 0) ? 70 : 30;
            pr = (ph % 2 == 0) ? 35 : 75;
            for (int i = 0; i < 600; i++) begin
                step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                     DW'($urandom), ($urandom_range(0, 19) == 0),
                     ($urandom_range(0, 199) == 0));
            end
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sync_fifo_gen2.md
SYNC_FIFO_GEN2 -- requirements
Module: sync_fifo_gen2

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, the storage entry count; any integer >= 2, not restricted to a power of two.
REQ-003 The block SHALL have parameter SHOW_AHEAD, default 0: 0 selects normal read mode, 1 selects first-word-fall-through mode.
REQ-004 The block SHALL have parameter AF_LEVEL, default DEPTH-2, the almost_full threshold.
REQ-005 The block SHALL have parameter AE_LEVEL, default 2, the almost_empty threshold.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all logic samples on its rising edge.
REQ-007 The block SHALL have port sclr, input, 1 bit; reset is synchronous and active-high.
REQ-008 The block SHALL have port din, input, DATA_WIDTH bits, the write data.
REQ-009 The block SHALL have port wr_en, input, 1 bit, the write request.
REQ-010 The block SHALL have port rd_en, input, 1 bit, the read request (pop acknowledge in SHOW_AHEAD=1).
REQ-011 The block SHALL have port flag_clr, input, 1 bit, which clears the sticky error flags.
REQ-012 The block SHALL have port dout, output, DATA_WIDTH bits, the read data.
REQ-013 The block SHALL have ports full, almost_full, empty and almost_empty, each an output of 1 bit, giving the level status.
REQ-014 The block SHALL have ports overflow and underflow, each an output of 1 bit, as sticky error flags.
REQ-015 The block SHALL have port usedw, output, $clog2(DEPTH+1) bits, the number of stored words.

Function
REQ-016 Write accept SHALL be wr_acc = wr_en && (!full || rd_acc).
- A write SHALL be accepted while full only when a read is accepted in the same cycle.
REQ-017 Read accept SHALL be rd_acc = rd_en && !empty.
- A write to an empty FIFO SHALL never be readable in the same cycle.
REQ-018 On wr_acc, din SHALL be stored at wr_ptr.
- wr_ptr SHALL advance by 1, wrapping from DEPTH-1 to 0.
REQ-019 On rd_acc, rd_ptr SHALL advance by 1, wrapping from DEPTH-1 to 0.
REQ-020 usedw SHALL change as follows:
- +1 on write-only accept.
- -1 on read-only accept.
- unchanged on simultaneous accept or no accept.
- It SHALL never exceed DEPTH or go below 0.
REQ-021 All status outputs SHALL be registered and update in the same cycle as usedw:
- full = (usedw==DEPTH)
- empty = (usedw==0)
- almost_full = (usedw>=AF_LEVEL)
- almost_empty = (usedw<=AE_LEVEL)
REQ-022 In SHOW_AHEAD=0, rd_acc SHALL load the word at rd_ptr into dout at the next rising edge (1-cycle latency).
- Otherwise dout SHALL hold its value.
REQ-023 In SHOW_AHEAD=1, dout SHALL present the word at rd_ptr whenever empty=0, and 0 whenever empty=1.
- rd_acc SHALL pop it so that the next word appears in the following cycle.
REQ-024 In SHOW_AHEAD=1, a word written to an empty FIFO SHALL appear on dout in the cycle empty deasserts, one cycle after the write edge.
REQ-025 overflow SHALL set when wr_en && full && !rd_acc, and SHALL stay set until flag_clr or sclr.
- The rejected word SHALL be dropped and the contents left unchanged.
REQ-026 underflow SHALL set when rd_en && empty, regardless of wr_en, and SHALL stay set until flag_clr or sclr.
- Pointers and dout SHALL be unchanged by the rejected read.
REQ-027 If flag_clr and a new error occur in the same cycle, the flag SHALL end set (set wins).
REQ-028 Storage contents SHALL not be cleared by any input.
- Stale entries SHALL never be visible, because dout is gated by empty (mode 1) or by rd_acc (mode 0).

Reset
REQ-029 When sclr=1 at a rising edge, regardless of all other inputs:
- wr_ptr=0, rd_ptr=0, usedw=0.
- empty=1, full=0.
- almost_empty=(0<=AE_LEVEL), almost_full=(0>=AF_LEVEL).
- overflow=0, underflow=0, dout=0.
REQ-030 sclr asserted mid-operation SHALL discard all stored words.
- Inputs in the sclr cycle SHALL be ignored.
- Normal operation SHALL resume on the first edge with sclr=0.

Verification
REQ-031 The bench SHALL use DEPTH=5, DATA_WIDTH=8, SHOW_AHEAD=0 and cover the following.
- Fill and drain: write 0x11..0x55 -> full=1, usedw=5, almost_full from usedw=3. Then read 5 -> dout is 0x11..0x55, each one cycle after its rd_en, and empty=1.
- Wrap-around: 3 writes, 3 reads, then 5 writes and 5 reads -> order preserved across the pointer wrap at index 4, no loss.
- Full with simultaneous read and write: with the FIFO full, wr_en=rd_en=1 and din=0xAA -> usedw stays 5, full stays 1, overflow=0, and 0xAA is read last.
- Errors: write while full without a read -> overflow=1 and contents unchanged. Read while empty -> underflow=1. flag_clr -> both 0.
REQ-032 The bench SHALL also cover the following.
- SHOW_AHEAD=1: write 0x5A to an empty FIFO -> the next cycle gives empty=0 and dout=0x5A with no rd_en; rd_en -> empty=1 and dout=0.
- Reset mid-operation: with 3 words stored, sclr=1 together with wr_en=1 -> usedw=0, empty=1, dout=0, and the write is ignored. A subsequent read sets underflow.
